// File: rtl/pl_reset_sequencer.sv
// Sequenced PL reset generator: synchronizes PS reset, clock lock and software reset, then
// releases interconnect reset first and peripheral reset STAGGER cycles later.
// Optional release counter is enabled by defining PL_RST_SEQ_STATUS_EN.
module pl_reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             pl_clk0,
  input  logic             pl_reset,
  input  logic             ext_resetn,
  input  logic             dcm_locked,
  input  logic             aux_reset,
  output logic             interconnect_aresetn,
  output logic             peripheral_aresetn,
  output logic             peripheral_reset,
  output logic             rst_active,
  output logic [CNT_W-1:0] release_count
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER - 1);

  typedef enum logic [1:0] {StReset, StHold, StRelIc, StRun} state_e;

  // Synchronizers reset to the "reset requested" level of each input.
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] aux_sync_q, aux_sync_d;
  logic                   req_rst;

  always_comb begin
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_resetn};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], dcm_locked};
    aux_sync_d  = {aux_sync_q[SYNC_STAGES-2:0], aux_reset};
    req_rst     = ~ext_sync_q[SYNC_STAGES-1] | ~lock_sync_q[SYNC_STAGES-1] |
                  aux_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge pl_clk0 or posedge pl_reset) begin
    if (pl_reset) begin
      ext_sync_q  <= '0;
      lock_sync_q <= '0;
      aux_sync_q  <= '1;
    end else begin
      ext_sync_q  <= ext_sync_d;
      lock_sync_q <= lock_sync_d;
      aux_sync_q  <= aux_sync_d;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ic_q, ic_d;
  logic            pr_q, pr_d;
  logic            prst_q, prst_d;
  logic            act_q, act_d;

  // A reset request always wins over a pending release step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StReset: begin
        cnt_d = '0;
        if (!req_rst) state_d = StHold;
      end
      StHold: begin
        if (req_rst) begin
          state_d = StReset;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRelIc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelIc: begin
        if (req_rst) begin
          state_d = StReset;
          cnt_d   = '0;
        end else if (cnt_q == StagLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        cnt_d = '0;
        if (req_rst) state_d = StReset;
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
    ic_d   = (state_d == StRelIc) || (state_d == StRun);
    pr_d   = (state_d == StRun);
    prst_d = (state_d != StRun);
    act_d  = (state_d != StRun);
  end

  always_ff @(posedge pl_clk0 or posedge pl_reset) begin
    if (pl_reset) begin
      state_q <= StReset;
      cnt_q   <= '0;
      ic_q    <= 1'b0;
      pr_q    <= 1'b0;
      prst_q  <= 1'b1;
      act_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ic_q    <= ic_d;
      pr_q    <= pr_d;
      prst_q  <= prst_d;
      act_q   <= act_d;
    end
  end

  assign interconnect_aresetn = ic_q;
  assign peripheral_aresetn   = pr_q;
  assign peripheral_reset     = prst_q;
  assign rst_active           = act_q;

`ifdef PL_RST_SEQ_STATUS_EN
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;

  always_comb begin
    rel_cnt_d = rel_cnt_q;
    if ((state_d == StRun) && (state_q != StRun) && (rel_cnt_q != '1)) begin
      rel_cnt_d = rel_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pl_clk0 or posedge pl_reset) begin
    if (pl_reset) rel_cnt_q <= '0;
    else          rel_cnt_q <= rel_cnt_d;
  end

  assign release_count = rel_cnt_q;
`else
  assign release_count = '0;
`endif

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Directed bench for pl_reset_sequencer: expected output edges are queued when stimulus is
// applied and checked as the DUT outputs change. A CNT_W=2 instance covers saturation.
module tb_pl_reset_sequencer;

  logic pl_clk0    = 1'b0;
  logic pl_reset   = 1'b1;
  logic ext_resetn = 1'b1;
  logic dcm_locked = 1'b1;
  logic aux_reset  = 1'b0;

  logic       ic, pr, prst, act;
  logic [7:0] rc;
  logic       ic_s, pr_s, prst_s, act_s;
  logic [1:0] rc_s;

  pl_reset_sequencer dut (
    .pl_clk0              (pl_clk0),
    .pl_reset             (pl_reset),
    .ext_resetn           (ext_resetn),
    .dcm_locked           (dcm_locked),
    .aux_reset            (aux_reset),
    .interconnect_aresetn (ic),
    .peripheral_aresetn   (pr),
    .peripheral_reset     (prst),
    .rst_active           (act),
    .release_count        (rc)
  );

  pl_reset_sequencer #(.CNT_W(2)) dut_sat (
    .pl_clk0              (pl_clk0),
    .pl_reset             (pl_reset),
    .ext_resetn           (ext_resetn),
    .dcm_locked           (dcm_locked),
    .aux_reset            (aux_reset),
    .interconnect_aresetn (ic_s),
    .peripheral_aresetn   (pr_s),
    .peripheral_reset     (prst_s),
    .rst_active           (act_s),
    .release_count        (rc_s)
  );

  always #5 pl_clk0 = ~pl_clk0;

  int edge_cnt = 0;
  always @(posedge pl_clk0) edge_cnt <= edge_cnt + 1;

  int checks   = 0;
  int failures = 0;
  int n_rel    = 0;

  typedef struct {
    string tag;
    int    sel;
    logic  val;
    int    edge_no;
  } ev_t;
  ev_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_rc(input int n, input int w);
`ifdef PL_RST_SEQ_STATUS_EN
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  function automatic logic sig_of(input int sel);
    return (sel == 0) ? ic : pr;
  endfunction

  task automatic push(input string tag, input int sel, input logic val, input int e);
    ev_t ev;
    ev.tag = tag; ev.sel = sel; ev.val = val; ev.edge_no = e;
    sb.push_back(ev);
  endtask

  // Wait (bounded) for the queued output change, then compare the edge it happened on.
  task automatic pop_check();
    ev_t e;
    bit  seen = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 80; i++) begin
      if (sig_of(e.sel) === e.val) begin
        seen = 1'b1;
        break;
      end
      @(negedge pl_clk0);
    end
    if (seen) chk(e.tag, edge_cnt, e.edge_no);
    else      chk({e.tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_rc"}, 32'(rc), 32'(exp_rc(n_rel, 8)));
    chk({tag, "_rc_sat"}, 32'(rc_s), 32'(exp_rc(n_rel, 2)));
  endtask

  task automatic release_por();
    int r;
    @(negedge pl_clk0);
    pl_reset = 1'b0;
    r = edge_cnt;
    push("por_ic_rise", 0, 1'b1, r + 19);
    push("por_pr_rise", 1, 1'b1, r + 23);
    pop_check();
    chk("por_pr_low_at_ic", 32'(pr), 32'd0);
    chk("por_active_at_ic", 32'(act), 32'd1);
    pop_check();
    n_rel++;
    chk("por_active_run", 32'(act), 32'd0);
    chk("por_prst_run", 32'(prst), 32'd0);
    check_counts("por");
  endtask

  task automatic lock_loss();
    int r;
    @(negedge pl_clk0);
    dcm_locked = 1'b0;
    r = edge_cnt;
    @(negedge pl_clk0);
    dcm_locked = 1'b1;
    push("lock_ic_fall", 0, 1'b0, r + 3);
    push("lock_pr_fall", 1, 1'b0, r + 3);
    push("lock_ic_rise", 0, 1'b1, r + 20);
    push("lock_pr_rise", 1, 1'b1, r + 24);
    pop_check();
    pop_check();
    chk("lock_active", 32'(act), 32'd1);
    chk("lock_prst", 32'(prst), 32'd1);
    pop_check();
    pop_check();
    n_rel++;
    check_counts("lock");
  endtask

  initial begin
    int a;
    repeat (5) @(negedge pl_clk0);
    chk("rst_ic", 32'(ic), 32'd0);
    chk("rst_pr", 32'(pr), 32'd0);
    chk("rst_prst", 32'(prst), 32'd1);
    chk("rst_active", 32'(act), 32'd1);
    chk("rst_rc", 32'(rc), 32'd0);

    release_por();
    lock_loss();

    // Software reset pulse, then abort the following HOLD when cnt has reached 10.
    @(negedge pl_clk0);
    aux_reset = 1'b1;
    a = edge_cnt;
    @(negedge pl_clk0);
    aux_reset = 1'b0;
    push("aux_ic_fall", 0, 1'b0, a + 3);
    pop_check();
    while (edge_cnt < a + 14) @(negedge pl_clk0);
    aux_reset = 1'b1;
    @(negedge pl_clk0);
    aux_reset = 1'b0;
    push("abort_ic_rise", 0, 1'b1, a + 34);
    pop_check();
    chk("abort_pr_low", 32'(pr), 32'd0);

    // Asynchronous reset while in REL_IC, between clock edges.
    @(posedge pl_clk0);
    #2;
    pl_reset = 1'b1;
    #1;
    n_rel = 0;
    chk("async_ic", 32'(ic), 32'd0);
    chk("async_pr", 32'(pr), 32'd0);
    chk("async_prst", 32'(prst), 32'd1);
    chk("async_active", 32'(act), 32'd1);
    check_counts("async");
    repeat (5) @(negedge pl_clk0);

    release_por();
    repeat (4) lock_loss();

    chk("sat_ic", 32'(ic_s), 32'd1);
    chk("sat_pr", 32'(pr_s), 32'd1);
    chk("sat_active", 32'(act_s), 32'd0);
    chk("sat_prst", 32'(prst_s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_reset_sequencer.md
# pl_reset_sequencer

Consumes the PS `pl_resetn` and clocking-wizard `locked` indications and produces the sequenced, synchronized resets that the PL fabric on `pl_clk0` sees. It is the receiving end of the PS→PL reset handshake: the PS drives `pl_resetn`, and this block qualifies it against clock lock. It then releases interconnect reset first and peripheral reset a fixed number of cycles later. It sits between `ps_wizard_0` / `clk_wizard_0` and every PL AXI master and slave in the platform.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in each input synchronizer; legal range 2–4.
- `HOLD_CYCLES`, 16: cycles all inputs must stay clean before interconnect release; must be ≥1.
- `STAGGER`, 4: cycles between interconnect release and peripheral release; must be ≥1.
- `CNT_W`, 8: width of `release_count`.

Ports:
- `pl_clk0`, in, 1: sole clock.
- `pl_reset`, in, 1: asynchronous, active-high power-on reset.
- `ext_resetn`, in, 1: PS `pl_resetn`. Asynchronous to `pl_clk0`, active-low.
- `dcm_locked`, in, 1: clocking-wizard lock. Asynchronous, active-high.
- `aux_reset`, in, 1: software reset request. Asynchronous, active-high.
- `interconnect_aresetn`, out, 1: active-low interconnect reset.
- `peripheral_aresetn`, out, 1: active-low peripheral reset.
- `peripheral_reset`, out, 1: active-high copy of peripheral reset; always equals `~peripheral_aresetn`.
- `rst_active`, out, 1: high while in any state other than RUN.
- `release_count`, out, CNT_W: number of entries into RUN, saturating.

## Operation
- Synchronization: `ext_resetn`, `dcm_locked` and `aux_reset` each pass through a SYNC_STAGES-flop synchronizer.
  - Synchronizer flops reset to the asserted-reset value: `ext_resetn`→0, `dcm_locked`→0, `aux_reset`→1.
  - `req_rst = ~ext_resetn_s | ~dcm_locked_s | aux_reset_s`.
- State machine states: RESET, HOLD, REL_IC, RUN. A single counter `cnt` is sized to max(HOLD_CYCLES, STAGGER).
- RESET:
  - `cnt`=0.
  - Transition to HOLD on the first edge where `req_rst`=0.
- HOLD:
  - `cnt` increments each edge.
  - If `req_rst`=1, go to RESET.
  - When `cnt`==HOLD_CYCLES-1, go to REL_IC and clear `cnt`.
- REL_IC:
  - `cnt` increments each edge.
  - If `req_rst`=1, go to RESET.
  - When `cnt`==STAGGER-1, go to RUN.
- RUN:
  - Stays in RUN while `req_rst`=0.
  - `req_rst`=1 sends the FSM to RESET.
  - `release_count` increments on each transition into RUN and saturates at 2^CNT_W-1.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - `interconnect_aresetn`=1 in REL_IC and RUN.
  - `peripheral_aresetn`=1 in RUN only.
- `pl_reset`=1 asynchronously forces state RESET, clears `cnt` and all synchronizers, and drives every reset output asserted. `release_count` also clears.
- Simultaneous events: `req_rst` rising on the same edge as a HOLD→REL_IC or REL_IC→RUN transition wins; the FSM goes to RESET.

## Timing
- Reset values:
  - `interconnect_aresetn`=0, `peripheral_aresetn`=0, `peripheral_reset`=1.
  - `rst_active`=1, `release_count`=0.
- Release latency is counted from the first `pl_clk0` edge sampling `ext_resetn`=1, with the other inputs already clean:
  - `interconnect_aresetn` rises after SYNC_STAGES+HOLD_CYCLES+1 edges (19 with defaults).
  - `peripheral_aresetn` rises STAGGER edges later (23 with defaults).
- Assertion latency from RUN: an input going to its reset value asserts all reset outputs SYNC_STAGES+1 edges later (3 with defaults).
- Glitch rejection: a `req_rst` pulse shorter than one cycle after synchronization still forces a full HOLD restart. No partial release ever occurs.

## Configuration
- `PL_RST_SEQ_STATUS_EN`:
  - Defined: `release_count` is implemented as specified.
  - Undefined: `release_count` is tied to 0 and its counter is removed. The FSM and reset outputs are unchanged.

## Test plan
- Power-on: assert `pl_reset` for 5 cycles with `ext_resetn`=1 and `dcm_locked`=1, then release.
  - Required: `interconnect_aresetn` rises 19 edges after release, `peripheral_aresetn` rises 4 edges later, `release_count`=1.
- Lock loss in RUN: drop `dcm_locked` for 1 cycle.
  - Required: all resets assert 3 edges later and the full 19/23-edge release sequence repeats; `release_count`=2.
- Mid-HOLD abort: pulse `aux_reset` when `cnt`=10.
  - Required: FSM returns to RESET, `interconnect_aresetn` stays 0, and the release occurs 19 edges after `aux_reset` is sampled low.
- Async reset mid-REL_IC: assert `pl_reset` between rising edges.
  - Required: `interconnect_aresetn`=0 immediately without a clock edge; `release_count` cleared.
- Saturation: set `CNT_W`=2 and force 5 reset/release cycles.
  - Required: `release_count` holds at 3.
- Macro off: rerun the power-on test.
  - Required: identical reset timing, with `release_count` constantly 0.
